// File: rtl/uart_frame_gen_if.sv
// uart_frame_gen_if: frame request channel (valid/ready handshake plus per-frame payload and format controls); master drives requests, slave accepts them
interface uart_frame_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  FRAME_VALID;
  logic                  FRAME_READY;
  logic [DATA_WIDTH-1:0] FRAME_DATA;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic                  ERR_PAR;
  logic                  ERR_STOP;
  modport master (
    output FRAME_VALID, FRAME_DATA, PAR_EN, PAR_TYP, STOP2, ERR_PAR, ERR_STOP,
    input  FRAME_READY
  );
  modport slave (
    input  FRAME_VALID, FRAME_DATA, PAR_EN, PAR_TYP, STOP2, ERR_PAR, ERR_STOP,
    output FRAME_READY
  );
endinterface

// File: rtl/uart_frame_gen.sv
// uart_frame_gen: UART frame generator; CLK/RST (sync, active-high), BIT_CYCLES/GAP_CYCLES timing, req frame channel, TX_OUT serial line, BUSY, DONE end-of-frame pulse
module uart_frame_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CNT_WIDTH-1:0] BIT_CYCLES,
  input  logic [CNT_WIDTH-1:0] GAP_CYCLES,
  uart_frame_gen_if.slave      req,
  output logic                 TX_OUT,
  output logic                 BUSY,
  output logic                 DONE
);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;
  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d, gap_cnt_q, gap_cnt_d;
  logic [CNT_WIDTH-1:0]  bits_q, bits_d, gap_q, gap_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  stop_q, stop_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic                  err_par_q, err_par_d, err_stop_q, err_stop_d;
  logic                  tx_q, tx_d;
  logic                  accept, bit_end, last_stop;
  assign req.FRAME_READY = state_q == IDLE && !RST;
  assign accept          = req.FRAME_VALID && req.FRAME_READY;
  assign bit_end         = bit_cnt_q == bits_q - 1'b1;
  assign last_stop       = stop_q == stop2_q;
  assign DONE            = state_q == STOP && bit_end && last_stop && !RST;
  assign BUSY            = state_q != IDLE;
  assign TX_OUT          = tx_q;
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_end ? '0 : bit_cnt_q + 1'b1;
    gap_cnt_d  = '0;
    idx_d      = idx_q;
    stop_d     = stop_q;
    data_d     = data_q;
    bits_d     = bits_q;
    gap_d      = gap_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    stop2_d    = stop2_q;
    err_par_d  = err_par_q;
    err_stop_d = err_stop_q;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (accept) begin
          state_d    = START;
          idx_d      = '0;
          stop_d     = 1'b0;
          data_d     = req.FRAME_DATA;
          par_en_d   = req.PAR_EN;
          par_typ_d  = req.PAR_TYP;
          stop2_d    = req.STOP2;
          err_par_d  = req.ERR_PAR;
          err_stop_d = req.ERR_STOP;
          bits_d     = BIT_CYCLES == '0 ? CNT_WIDTH'(1) : BIT_CYCLES;
          gap_d      = GAP_CYCLES;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        stop_d = 1'b1;
        if (last_stop) state_d = gap_q != '0 ? GAP : IDLE;
      end
      GAP: begin
        bit_cnt_d = '0;
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == gap_q - 1'b1) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // TX is registered, so it is derived from the state being entered
    tx_d = state_d == START  ? 1'b0 :
           state_d == DATA   ? data_d[idx_d] :
           state_d == PARITY ? ^data_d ^ par_typ_d ^ err_par_d :
           state_d == STOP   ? stop_d || !err_stop_d : 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      data_q     <= '0;
      bits_q     <= CNT_WIDTH'(1);
      gap_q      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      err_par_q  <= 1'b0;
      err_stop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      data_q     <= data_d;
      bits_q     <= bits_d;
      gap_q      <= gap_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
      err_par_q  <= err_par_d;
      err_stop_q <= err_stop_d;
    end
  end
endmodule

// File: tb/tb_uart_frame_gen.sv
// tb_uart_frame_gen: scoreboard bench comparing the serial line against a bit-list reference model
module tb_uart_frame_gen;
  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] BIT_CYCLES, GAP_CYCLES;
  logic       TX_OUT, BUSY, DONE;
  int         checks = 0;
  int         errors = 0;
  always #5 CLK = ~CLK;
  uart_frame_gen_if #(.DATA_WIDTH(8)) bus();
  uart_frame_gen #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .BIT_CYCLES(BIT_CYCLES), .GAP_CYCLES(GAP_CYCLES),
    .req(bus), .TX_OUT(TX_OUT), .BUSY(BUSY), .DONE(DONE)
  );
  typedef struct {
    logic [15:0] bits;
    int          nb;
    int          b;
    int          gap;
    bit          b2b;
  } exp_t;
  exp_t exp_q[$];
  exp_t cur;
  logic active = 1'b0;
  int   k, idle_run, bi;
  logic e_tx;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask
  function automatic exp_t model(input logic [7:0] d, input logic pe, pt, s2, ep, es,
                                 input logic [7:0] bc, gc, input bit b2b);
    exp_t e;
    int   n, ones;
    e.bits = '0;
    ones = 0;
    e.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e.bits[1 + i] = d[i];
      ones += int'(d[i]);
    end
    n = 9;
    if (pe) begin
      e.bits[n] = (ones % 2 == 1) ^ pt ^ ep;
      n++;
    end
    e.bits[n] = !es;
    n++;
    if (s2) begin
      e.bits[n] = 1'b1;
      n++;
    end
    e.nb  = n;
    e.b   = bc == 0 ? 1 : int'(bc);
    e.gap = int'(gc);
    e.b2b = b2b;
    return e;
  endfunction
  always @(negedge CLK) begin
    if (RST) begin
      active   = 1'b0;
      idle_run = 0;
      exp_q.delete();
    end else begin
      if (!active && BUSY) begin
        if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
        else begin
          cur    = exp_q.pop_front();
          active = 1'b1;
          k      = 0;
          if (cur.b2b) chk("b2b_idle_cycles", idle_run, 1);
        end
      end
      if (active) begin
        bi   = k / cur.b;
        e_tx = bi < cur.nb ? cur.bits[bi] : 1'b1;
        chk("tx", TX_OUT, e_tx);
        chk("done", DONE, k == cur.nb * cur.b - 1);
        chk("busy", BUSY, 1);
        chk("ready_busy", bus.FRAME_READY, 0);
        k++;
        if (k == cur.nb * cur.b + cur.gap) begin
          active   = 1'b0;
          idle_run = 0;
        end
      end else begin
        chk("idle_tx", TX_OUT, 1);
        chk("idle_busy", BUSY, 0);
        chk("idle_done", DONE, 0);
        chk("idle_ready", bus.FRAME_READY, 1);
        idle_run++;
      end
    end
  end
  task automatic junk();
    bus.FRAME_DATA = 8'($urandom);
    bus.PAR_EN     = 1'($urandom);
    bus.PAR_TYP    = 1'($urandom);
    bus.STOP2      = 1'($urandom);
    bus.ERR_PAR    = 1'($urandom);
    bus.ERR_STOP   = 1'($urandom);
    BIT_CYCLES     = 8'($urandom);
    GAP_CYCLES     = 8'($urandom);
  endtask
  task automatic send(input logic [7:0] d, input logic pe, pt, s2, ep, es,
                      input logic [7:0] bc, gc, input bit hold);
    bit b2b;
    int t;
    b2b = bus.FRAME_VALID;
    bus.FRAME_DATA  = d;
    bus.PAR_EN      = pe;
    bus.PAR_TYP     = pt;
    bus.STOP2       = s2;
    bus.ERR_PAR     = ep;
    bus.ERR_STOP    = es;
    BIT_CYCLES      = bc;
    GAP_CYCLES      = gc;
    bus.FRAME_VALID = 1'b1;
    t = 0;
    @(negedge CLK);
    while (!bus.FRAME_READY && t < 5000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 5000) begin
      chk("accept_timeout", t, 0);
      bus.FRAME_VALID = 1'b0;
      return;
    end
    exp_q.push_back(model(d, pe, pt, s2, ep, es, bc, gc, b2b));
    @(posedge CLK);
    #1;
    if (!hold) begin
      bus.FRAME_VALID = 1'b0;
      junk();
    end
  endtask
  initial begin
    int t;
    RST = 1'b1;
    bus.FRAME_VALID = 1'b0;
    junk();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_ready", bus.FRAME_READY, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    send(8'hAA, 1, 0, 0, 0, 0, 8'd4, 8'd0, 0);
    send(8'h04, 1, 1, 0, 0, 0, 8'd4, 8'd0, 0);
    send(8'h04, 1, 0, 0, 0, 0, 8'd4, 8'd0, 0);
    send(8'h04, 0, 0, 0, 0, 0, 8'd4, 8'd0, 0);
    send(8'hAA, 1, 0, 0, 1, 0, 8'd4, 8'd0, 0);
    send(8'hAA, 1, 0, 1, 0, 1, 8'd4, 8'd0, 0);
    send(8'hAA, 1, 0, 0, 0, 0, 8'd4, 8'd0, 1);
    send(8'h00, 1, 0, 0, 0, 0, 8'd4, 8'd0, 1);
    send(8'h04, 1, 0, 0, 0, 0, 8'd4, 8'd0, 0);
    send(8'h55, 1, 0, 0, 0, 0, 8'd4, 8'd10, 0);
    send(8'h3C, 1, 1, 1, 0, 0, 8'd0, 8'd0, 0);
    send(8'h5A, 0, 0, 1, 0, 0, 8'd2, 8'd3, 1);
    send(8'hA5, 1, 1, 0, 0, 0, 8'd3, 8'd0, 0);
    send(8'hC3, 1, 0, 0, 0, 0, 8'd255, 8'd255, 0);
    send(8'hAA, 1, 0, 0, 0, 0, 8'd4, 8'd0, 0);
    repeat (8) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    chk("done_during_rst", DONE, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_tx", TX_OUT, 1);
    chk("post_rst_busy", BUSY, 0);
    @(posedge CLK);
    #1;
    send(8'h96, 1, 1, 0, 0, 0, 8'd2, 8'd0, 0);
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom_range(0, 5)),
           $urandom_range(0, 3) == 0 ? 8'($urandom_range(1, 12)) : 8'd0,
           i != 39 && $urandom_range(0, 2) == 0);
      if (!bus.FRAME_VALID) repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
    end
    t = 0;
    while ((exp_q.size() != 0 || active || BUSY) && t < 20000) begin
      @(posedge CLK);
      t++;
    end
    chk("drain_timeout", t < 20000, 1);
    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
